// File: rtl/u_add_rr_arbiter_pkg.sv
// Shared definitions for the round-robin nibble-adder arbiter:
// default widths, requester-ID width helper and result-slot state encoding.
package u_add_rr_arbiter_pkg;

  localparam int W_DEFAULT     = 4;
  localparam int N_REQ_DEFAULT = 4;

  // Result slot states: EMPTY means o_res_valid=0, FULL means a result is held.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Requester ID width; at least one bit so a 2-requester build still has an ID.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/u_add_rr_arbiter_if.sv
// Request/result bus of the round-robin adder arbiter.
// master: requester/consumer side, slave: arbiter side.
// U_ADD_RR_ARBITER_OVF_EN adds the o_res_ovf carry-out signal.
interface u_add_rr_arbiter_if
  import u_add_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int W     = W_DEFAULT,
  parameter int ID_W  = id_w(N_REQ)
);

  logic [N_REQ-1:0]   i_req_valid;
  logic [N_REQ*W-1:0] i_req_A;
  logic [N_REQ*W-1:0] i_req_B;
  logic [N_REQ-1:0]   o_req_ready;
  logic               o_res_valid;
  logic [W-1:0]       o_res_Z;
  logic [ID_W-1:0]    o_res_id;
  logic               i_res_ready;
`ifdef U_ADD_RR_ARBITER_OVF_EN
  logic               o_res_ovf;
`endif

  modport master (
    output i_req_valid, i_req_A, i_req_B, i_res_ready,
    input  o_req_ready, o_res_valid, o_res_Z, o_res_id
`ifdef U_ADD_RR_ARBITER_OVF_EN
    , input o_res_ovf
`endif
  );

  modport slave (
    input  i_req_valid, i_req_A, i_req_B, i_res_ready,
    output o_req_ready, o_res_valid, o_res_Z, o_res_id
`ifdef U_ADD_RR_ARBITER_OVF_EN
    , output o_res_ovf
`endif
  );

endinterface

// File: rtl/u_add_rr_arbiter_add.sv
// Wrap-around adder: z = (a + b) mod 2^W, carry discarded.
module u_add_wo_carry #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] z
);

  // Sum truncated to W bits; overflow wraps silently.
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] x, input logic [W-1:0] y);
    return x + y;
  endfunction

  assign z = wrap_add(a, b);

endmodule

// File: rtl/u_add_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: the first valid index at or after ptr
// (mod N_REQ) wins. Produces a one-hot grant, its index and a found flag.
module u_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             found
);

  logic [ID_W-1:0] k;

  // Scan N_REQ positions starting at ptr; the first valid one is granted.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = ID_W'((int'(ptr) + i) % N_REQ);
      if (!found && valid[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/u_add_rr_arbiter.sv
// Round-robin arbiter sharing one wrap-around adder between N_REQ requesters.
// One request accepted per cycle into a single result slot held under a
// downstream valid/ready handshake; ptr advances past each accepted winner.
// U_ADD_RR_ARBITER_OVF_EN adds o_res_ovf (carry out, registered with the sum).
module u_add_rr_arbiter
  import u_add_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int W     = W_DEFAULT,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  u_add_rr_arbiter_if.slave bus
);

`ifdef U_ADD_RR_ARBITER_OVF_EN
  // Carry out of an unsigned W-bit add.
  function automatic logic carry_out(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[W];
  endfunction
`endif

  logic [0:0]      state_p1;
  logic [ID_W-1:0] ptr_p1;
  logic [W-1:0]    res_z_p1;
  logic [ID_W-1:0] res_id_p1;
  logic            vld_p1;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  win_idx;
  logic             win_found;
  logic             slot_free;
  logic             accept;
  logic [W-1:0]     a_sel;
  logic [W-1:0]     b_sel;
  logic [W-1:0]     sum;
  logic [ID_W-1:0]  ptr_next;

  u_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .valid (bus.i_req_valid),
    .ptr   (ptr_p1),
    .grant (grant),
    .idx   (win_idx),
    .found (win_found)
  );

  // Winner operand mux driven by the one-hot grant; non-granted operands unused.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        a_sel = bus.i_req_A[k*W +: W];
        b_sel = bus.i_req_B[k*W +: W];
      end
    end
  end

  u_add_wo_carry #(
    .W (W)
  ) u_add (
    .a (a_sel),
    .b (b_sel),
    .z (sum)
  );

  // Slot can take a new result when empty or when the held one leaves this cycle.
  assign slot_free = (state_p1 == ST_EMPTY) || bus.i_res_ready;
  assign accept    = win_found && slot_free && !rst;
  assign ptr_next  = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  assign bus.o_req_ready = (slot_free && !rst) ? grant : '0;

  // Slot state and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= ST_EMPTY;
      ptr_p1   <= '0;
    end else if (accept) begin
      state_p1 <= ST_FULL;
      ptr_p1   <= ptr_next;
    end else if (state_p1 == ST_FULL && bus.i_res_ready) begin
      state_p1 <= ST_EMPTY;
    end
  end

  // ---- stage p1: result register, loaded only on accept, held on stall ----
  always_ff @(posedge clk) begin
    if (rst) begin
      res_z_p1  <= '0;
      res_id_p1 <= '0;
    end else if (accept) begin
      res_z_p1  <= sum;
      res_id_p1 <= win_idx;
    end
  end

`ifdef U_ADD_RR_ARBITER_OVF_EN
  logic res_ovf_p1;

  // Carry out registered alongside the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_ovf_p1 <= 1'b0;
    end else if (accept) begin
      res_ovf_p1 <= carry_out(a_sel, b_sel);
    end
  end

  assign bus.o_res_ovf = res_ovf_p1;
`endif

  assign vld_p1          = (state_p1 == ST_FULL);
  assign bus.o_res_valid = vld_p1;
  assign bus.o_res_Z     = res_z_p1;
  assign bus.o_res_id    = res_id_p1;

endmodule

// File: tb/tb_u_add_rr_arbiter.sv
// Bench for u_add_rr_arbiter: a directed cycle table followed by randomized
// traffic checked against a queue-free slot/pointer reference model.
module tb_u_add_rr_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  u_add_rr_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  u_add_rr_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        rr;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic        chk_data;
    logic [3:0]  exp_z;
    logic [1:0]  exp_id;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl [21];

  // Reference model state
  bit       m_full;
  int       m_ptr;
  int       m_z;
  int       m_id;
  bit       m_ovf;
  bit       pend [N];
  int       ra   [N];
  int       rb   [N];

  function automatic int rr_winner(input bit v [N], input int ptr);
    for (int i = 0; i < N; i++) begin
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  initial begin
    //            rst  valid  A         B         rr   ready  vld  chk  z     id    ovf
    tbl[0]  = '{1'b1, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'h4, 16'h0300, 16'h0400, 1'b1, 4'h4, 1'b1, 1'b1, 4'h7, 2'd2, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 4'h1, 16'h000F, 16'h0004, 1'b1, 4'h1, 1'b1, 1'b1, 4'h3, 2'd0, 1'b1};
    tbl[5]  = '{1'b0, 4'h2, 16'h0070, 16'h0010, 1'b1, 4'h2, 1'b1, 1'b1, 4'h8, 2'd1, 1'b0};
    tbl[6]  = '{1'b0, 4'hF, 16'h4321, 16'h1111, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 2'd2, 1'b0};
    tbl[7]  = '{1'b0, 4'hF, 16'h4321, 16'h1111, 1'b1, 4'h8, 1'b1, 1'b1, 4'h5, 2'd3, 1'b0};
    tbl[8]  = '{1'b0, 4'hF, 16'h4321, 16'h1111, 1'b1, 4'h1, 1'b1, 1'b1, 4'h2, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 4'hF, 16'h4321, 16'h1111, 1'b1, 4'h2, 1'b1, 1'b1, 4'h3, 2'd1, 1'b0};
    tbl[10] = '{1'b0, 4'hF, 16'h4321, 16'h1111, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 2'd2, 1'b0};
    tbl[11] = '{1'b0, 4'hF, 16'h4321, 16'h1111, 1'b0, 4'h0, 1'b1, 1'b1, 4'h4, 2'd2, 1'b0};
    tbl[12] = '{1'b0, 4'hF, 16'h4321, 16'h1111, 1'b0, 4'h0, 1'b1, 1'b1, 4'h4, 2'd2, 1'b0};
    tbl[13] = '{1'b0, 4'hF, 16'h4321, 16'h1111, 1'b0, 4'h0, 1'b1, 1'b1, 4'h4, 2'd2, 1'b0};
    tbl[14] = '{1'b0, 4'hF, 16'h4321, 16'h1111, 1'b1, 4'h8, 1'b1, 1'b1, 4'h5, 2'd3, 1'b0};
    tbl[15] = '{1'b1, 4'hF, 16'h4321, 16'h1111, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 2'd0, 1'b0};
    tbl[16] = '{1'b0, 4'hF, 16'h4321, 16'h1111, 1'b1, 4'h1, 1'b1, 1'b1, 4'h2, 2'd0, 1'b0};
    tbl[17] = '{1'b0, 4'h4, 16'h4321, 16'h1111, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 2'd2, 1'b0};
    tbl[18] = '{1'b0, 4'h4, 16'h4321, 16'h1111, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 2'd2, 1'b0};
    tbl[19] = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b1, 4'h4, 2'd2, 1'b0};
    tbl[20] = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0};

    rst             = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_A     = '0;
    bus.i_req_B     = '0;
    bus.i_res_ready = 1'b0;
    @(negedge clk);

    // Directed cycle table
    for (int r = 0; r < 21; r++) begin
      rst             = tbl[r].rst;
      bus.i_req_valid = tbl[r].valid;
      bus.i_req_A     = tbl[r].a;
      bus.i_req_B     = tbl[r].b;
      bus.i_res_ready = tbl[r].rr;
      #1;
      chk($sformatf("tbl%0d ready", r), 32'(bus.o_req_ready), 32'(tbl[r].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d valid", r), 32'(bus.o_res_valid), 32'(tbl[r].exp_valid));
      if (tbl[r].chk_data) begin
        chk($sformatf("tbl%0d z", r), 32'(bus.o_res_Z), 32'(tbl[r].exp_z));
        chk($sformatf("tbl%0d id", r), 32'(bus.o_res_id), 32'(tbl[r].exp_id));
`ifdef U_ADD_RR_ARBITER_OVF_EN
        chk($sformatf("tbl%0d ovf", r), 32'(bus.o_res_ovf), 32'(tbl[r].exp_ovf));
`endif
      end
      @(negedge clk);
    end

    // Randomized traffic against the reference model
    for (int k = 0; k < N; k++) pend[k] = 0;
    m_full = 0; m_ptr = 0; m_z = 0; m_id = 0; m_ovf = 0;
    for (int c = 0; c < 600; c++) begin
      bit rr;
      bit r_rst;
      int w;
      bit acc;
      int exp_ready;
      r_rst = (c == 0) || ($urandom_range(0, 49) == 0);
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 2) != 0) begin
          pend[k] = 1;
          ra[k]   = int'($urandom_range(0, 15));
          rb[k]   = int'($urandom_range(0, 15));
        end
      end
      rr = ($urandom_range(0, 3) != 0);

      rst             = r_rst;
      bus.i_res_ready = rr;
      for (int k = 0; k < N; k++) begin
        bus.i_req_valid[k]     = pend[k];
        bus.i_req_A[k*W +: W]  = W'(ra[k]);
        bus.i_req_B[k*W +: W]  = W'(rb[k]);
      end

      w         = rr_winner(pend, m_ptr);
      acc       = !r_rst && (w >= 0) && (!m_full || rr);
      exp_ready = acc ? (1 << w) : 0;
      #1;
      chk("rnd ready", 32'(bus.o_req_ready), 32'(exp_ready));
      @(posedge clk);
      if (r_rst) begin
        m_full = 0; m_ptr = 0; m_z = 0; m_id = 0; m_ovf = 0;
      end else if (acc) begin
        m_full  = 1;
        m_z     = (ra[w] + rb[w]) % 16;
        m_ovf   = (ra[w] + rb[w]) >= 16;
        m_id    = w;
        m_ptr   = (w + 1) % N;
        pend[w] = 0;
      end else if (m_full && rr) begin
        m_full = 0;
      end
      #1;
      chk("rnd valid", 32'(bus.o_res_valid), 32'(m_full));
      if (m_full || r_rst) begin
        chk("rnd z", 32'(bus.o_res_Z), 32'(m_z));
        chk("rnd id", 32'(bus.o_res_id), 32'(m_id));
`ifdef U_ADD_RR_ARBITER_OVF_EN
        chk("rnd ovf", 32'(bus.o_res_ovf), 32'(m_ovf));
`endif
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
